// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   WORD_W    : data/address width in bits (taken from `WORD, default 32)
//   BYTES     : byte lanes per word
//   state_t   : responder FSM states
//   clog2()   : counter width helper, never returns less than 1
`ifndef WORD
`define WORD 32
`endif

package dmem_pkg;

  localparam int WORD_W = `WORD;
  localparam int BYTES  = `WORD / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Bits needed to hold LATENCY-1; a 1-bit counter is kept even for
  // LATENCY==1 so the register never collapses to zero width.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM, depth 2^DMEM_POWER.
//   clk   : clock
//   we    : write strobe, bytes selected by be are written
//   re    : read strobe, rdata is loaded from mem[index] on the same edge
//   index : word index
//   wdata : write data
//   be    : byte enables, bit i controls bits [8i+7:8i]
//   rdata : registered read data, holds its value between reads
// Contents are not initialised and are not affected by reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DMEM_POWER = 18
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DMEM_POWER-1:0] index,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [BYTES-1:0]      be,
  output logic [WORD_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DMEM_POWER;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[index];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the data-memory load/store interface.
// One request is outstanding at a time; the response appears a fixed
// LATENCY cycles after the request is accepted.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Request fields are sampled only on that edge. Once rsp_valid
// rises, rsp_rdata and rsp_err stay constant until the response transfer.
// req_ready is high only in IDLE, so no request is taken while a response
// is pending.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address, wraps modulo the RAM size
//   req_wdata, req_be   : store data and byte enables (be ignored on loads)
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data, 0 for stores and flagged accesses
//   rsp_err             : misaligned access flag
//   dbg_state           : current FSM state
//
// Build option: define DMEM_ALIGN_CHECK_EN to flag accesses whose address
// is not word aligned. A flagged store leaves RAM untouched and the
// response carries rsp_err=1, rsp_rdata=0. Without it rsp_err is always 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DMEM_POWER = 18,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BYTES-1:0]  req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output state_t            dbg_state
);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be >= 1");
    end
  endgenerate

  localparam int CW = clog2(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  // Address bits that select the word; everything else is ignored.
  localparam logic [WORD_W-1:0] INDEX_MASK =
    ((WORD_W'(1) << DMEM_POWER) - WORD_W'(1)) << 2;

  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic accept, commit;

  // Request fields captured at acceptance.
  logic                  lat_we;
  logic [DMEM_POWER-1:0] lat_idx;
  logic [WORD_W-1:0]     lat_wdata;
  logic [BYTES-1:0]      lat_be;
  logic                  lat_err;

  // Response registers.
  logic rdata_sel;
  logic err_q;

  logic              misaligned;
  logic [WORD_W-1:0] ram_q;
  logic              unused_addr_bits;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = |req_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign unused_addr_bits = ^(req_addr & ~INDEX_MASK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = (LATENCY == 1) ? COMMIT : BUSY;
        end
      end
      BUSY: begin
        // Leave on the cycle the counter hits zero, giving LATENCY-1
        // BUSY cycles plus the COMMIT cycle.
        cnt_next = cnt - 1'b1;
        if (cnt_next == '0) state_next = COMMIT;
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_idx   <= req_addr[DMEM_POWER+1:2];
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
      lat_err   <= misaligned;
    end
  end

  // rdata_sel gates the RAM output register so that stores, flagged
  // accesses and the reset state all present zero on rsp_rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_sel <= 1'b0;
      err_q     <= 1'b0;
    end else if (commit) begin
      rdata_sel <= !lat_we && !lat_err;
      err_q     <= lat_err;
    end else if (state == RESP && rsp_ready) begin
      rdata_sel <= 1'b0;
      err_q     <= 1'b0;
    end
  end

  dmem_array #(
    .DMEM_POWER (DMEM_POWER)
  ) u_array (
    .clk   (clk),
    .we    (commit && lat_we && !lat_err),
    .re    (commit && !lat_we && !lat_err),
    .index (lat_idx),
    .wdata (lat_wdata),
    .be    (lat_be),
    .rdata (ram_q)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_sel ? ram_q : '0;
  assign rsp_err   = err_q;
  assign dbg_state = state;

endmodule
